// File: rtl/pipe_stall_sched.sv
// Stall/flush sequencer for the 5-stage pipeline: stage enables, bubble injects, halt and timeout detection.
// Optional total-stall performance counter is built when STALL_PERF_EN is defined.
module pipe_stall_sched #(
    parameter int JB_MAX    = 4,
    parameter int STALL_MAX = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        haz_req,
    input  logic        jb_req,
    input  logic        br_resolve,
    input  logic        br_taken,
    input  logic        mem_busy,
    input  logic        halt_wb,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_nop,
    output logic        id_ex_nop,
    output logic        halted,
    output logic        err,
    output logic [15:0] perf_stalls
);

    typedef enum logic [1:0] {RUN, JB_WAIT, MEM_WAIT, HALTED} state_t;

    localparam logic [3:0] JB_LIM    = 4'(JB_MAX);
    localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);

    state_t     state, state_next;
    logic       ret_jb, ret_jb_next;
    logic [3:0] jb_cnt, jb_cnt_next;
    logic [7:0] stall_cnt, stall_cnt_next;
    logic       in_jb, stall, jb_tick, hold_halt, err_next;

    // A MEM_WAIT cycle with memory done behaves exactly like the state it froze from.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_nop   = 1'b0;
        id_ex_nop   = 1'b0;
        state_next  = state;
        ret_jb_next = ret_jb;
        jb_cnt_next = jb_cnt;
        stall       = 1'b0;
        jb_tick     = 1'b0;
        in_jb       = (state == JB_WAIT) || ((state == MEM_WAIT) && ret_jb);
        hold_halt   = (state == HALTED) || halt_wb;

        if (!rst) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
            if_id_nop = 1'b1;
            id_ex_nop = 1'b1;
            hold_halt = 1'b0;
        end else if (hold_halt) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
            state_next = HALTED;
        end else if (mem_busy) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
            state_next  = MEM_WAIT;
            ret_jb_next = in_jb;
            stall       = 1'b1;
        end else if (br_resolve && br_taken) begin
            if_id_nop   = 1'b1;
            id_ex_nop   = 1'b1;
            state_next  = RUN;
            jb_cnt_next = 4'd0;
        end else if (in_jb && br_resolve) begin
            state_next  = RUN;
            jb_cnt_next = 4'd0;
        end else if (in_jb) begin
            pc_en       = 1'b0;
            if_id_nop   = 1'b1;
            state_next  = JB_WAIT;
            jb_cnt_next = (jb_cnt == 4'hF) ? jb_cnt : jb_cnt + 4'd1;
            stall       = 1'b1;
            jb_tick     = 1'b1;
        end else if (haz_req) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_nop  = 1'b1;
            state_next = RUN;
            stall      = 1'b1;
        end else if (jb_req) begin
            pc_en       = 1'b0;
            if_id_nop   = 1'b1;
            state_next  = JB_WAIT;
            jb_cnt_next = 4'd1;
            stall       = 1'b1;
            jb_tick     = 1'b1;
        end else begin
            state_next = RUN;
        end
    end

    always_comb begin
        stall_cnt_next = 8'd0;
        if (hold_halt)
            stall_cnt_next = stall_cnt;
        else if (stall)
            stall_cnt_next = (stall_cnt == 8'hFF) ? stall_cnt : stall_cnt + 8'd1;
        err_next = err
                 | (jb_tick && (jb_cnt_next >= JB_LIM))
                 | (stall && (stall_cnt_next >= STALL_LIM));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            ret_jb    <= 1'b0;
            jb_cnt    <= 4'd0;
            stall_cnt <= 8'd0;
            halted    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            ret_jb    <= ret_jb_next;
            jb_cnt    <= jb_cnt_next;
            stall_cnt <= stall_cnt_next;
            halted    <= (state_next == HALTED);
            err       <= err_next;
        end
    end

`ifdef STALL_PERF_EN
    logic [15:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (!rst)
            perf_cnt <= 16'd0;
        else if (stall && !hold_halt && (perf_cnt != 16'hFFFF))
            perf_cnt <= perf_cnt + 16'd1;
    end

    assign perf_stalls = perf_cnt;
`else
    assign perf_stalls = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stall_sched.sv
// Scoreboard bench for pipe_stall_sched: directed sequences plus randomized traffic
// checked against a behavioural model of the stall/flush rules.
module tb_pipe_stall_sched;

    localparam int JB_MAX    = 4;
    localparam int STALL_MAX = 10;

    logic        clk = 1'b0;
    logic        rst, haz_req, jb_req, br_resolve, br_taken, mem_busy, halt_wb;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_nop, id_ex_nop;
    logic        halted, err;
    logic [15:0] perf_stalls;

    always #5 clk = ~clk;

    pipe_stall_sched #(.JB_MAX(JB_MAX), .STALL_MAX(STALL_MAX)) dut (
        .clk(clk), .rst(rst), .haz_req(haz_req), .jb_req(jb_req),
        .br_resolve(br_resolve), .br_taken(br_taken), .mem_busy(mem_busy),
        .halt_wb(halt_wb), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_nop(if_id_nop),
        .id_ex_nop(id_ex_nop), .halted(halted), .err(err), .perf_stalls(perf_stalls)
    );

    typedef struct {
        bit          known;
        logic [4:0]  en;
        logic [1:0]  nop;
        logic        halted;
        logic        err;
        logic [15:0] perf;
        int          cycle;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: pipeline condition tracked as plain flags and counts.
    bit m_known = 0, m_halted = 0, m_err = 0, m_branch_pending = 0;
    int m_jb = 0, m_stall_run = 0, m_perf = 0;

    task automatic model_cycle(input bit r, h, mb, brr, brt, hz, jb, output exp_t e);
        bit stall_now = 0;
        e.known  = m_known;
        e.halted = m_halted;
        e.err    = m_err;
        e.perf   = 16'(m_perf);
        e.cycle  = cyc;
        e.en     = 5'b11111;
        e.nop    = 2'b00;
        if (!r) begin
            e.en = 5'b00000; e.nop = 2'b11;
            m_known = 1; m_halted = 0; m_err = 0; m_branch_pending = 0;
            m_jb = 0; m_stall_run = 0; m_perf = 0;
            return;
        end
        if (m_halted || h) begin
            e.en = 5'b00000;
            m_halted = 1;
            return;
        end
        if (mb) begin
            e.en = 5'b00000; stall_now = 1;
        end else if (brr && brt) begin
            e.nop = 2'b11; m_branch_pending = 0; m_jb = 0;
        end else if (m_branch_pending && brr) begin
            m_branch_pending = 0; m_jb = 0;
        end else if (m_branch_pending || (!hz && jb)) begin
            e.en = 5'b01111; e.nop = 2'b10; stall_now = 1;
            m_jb = m_branch_pending ? ((m_jb < 15) ? m_jb + 1 : 15) : 1;
            m_branch_pending = 1;
            if (m_jb >= JB_MAX) m_err = 1;
        end else if (hz) begin
            e.en = 5'b00111; e.nop = 2'b01; stall_now = 1;
        end
        if (stall_now) begin
            m_stall_run = (m_stall_run < 255) ? m_stall_run + 1 : 255;
            if (m_stall_run >= STALL_MAX) m_err = 1;
`ifdef STALL_PERF_EN
            if (m_perf < 65535) m_perf = m_perf + 1;
`endif
        end else begin
            m_stall_run = 0;
        end
    endtask

    task automatic check_output(input string name, input int c, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, c, act, req);
        end
    endtask

    task automatic apply_stimulus(input bit r, h, mb, brr, brt, hz, jb);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        rst = r; halt_wb = h; mem_busy = mb; br_resolve = brr; br_taken = brt;
        haz_req = hz; jb_req = jb;
        model_cycle(r, h, mb, brr, brt, hz, jb, e);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle presents outputs, so one expectation is consumed per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_output("enables", e.cycle,
                             16'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 16'(e.en));
                check_output("nops", e.cycle, 16'({if_id_nop, id_ex_nop}), 16'(e.nop));
                if (e.known) begin
                    check_output("halted", e.cycle, 16'(halted), 16'(e.halted));
                    check_output("err", e.cycle, 16'(err), 16'(e.err));
                    check_output("perf_stalls", e.cycle, perf_stalls, e.perf);
                end
            end
        end
    end

    initial begin
        int halt_len = 0;
        bit r, h, mb, brr, brt, hz, jb;

        do_reset();
        idle(2);

        apply_stimulus(1, 0, 0, 0, 0, 1, 0);
        apply_stimulus(1, 0, 0, 0, 0, 1, 0);
        idle(1);

        apply_stimulus(1, 0, 0, 0, 0, 0, 1);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 1, 1, 0, 0);
        idle(1);

        apply_stimulus(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 1, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 1, 0, 0, 0);
        idle(2);

        do_reset();
        apply_stimulus(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 1, 1, 0, 0);
        idle(2);

        do_reset();
        for (int i = 0; i < STALL_MAX + 1; i++) apply_stimulus(1, 0, 0, 0, 0, 1, 0);
        idle(2);

        do_reset();
        apply_stimulus(1, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++)
            apply_stimulus(1, 1'(i), 1'(i >> 1), 1'(i), 1'(i >> 2), 1, 1);
        do_reset();
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            halt_len = m_halted ? halt_len + 1 : 0;
            r   = !(($urandom_range(0, 149) == 0) || (halt_len > 8));
            h   = ($urandom_range(0, 299) == 0);
            mb  = ($urandom_range(0, 5) == 0);
            brr = !mb && ($urandom_range(0, 3) == 0);
            brt = $urandom_range(0, 1) == 1;
            hz  = ($urandom_range(0, 4) == 0);
            jb  = ($urandom_range(0, 4) == 0);
            apply_stimulus(r, h, mb, brr, brt, hz, jb);
        end
        idle(1);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
